sad_search_ctrl: RTL

//  Full-search motion-estimation scheduler for the 16x16 SAD aggregation datapath.
//  On start it walks every integer MV in [-RANGE, RANGE-1]^2 in raster order (dx fastest),
//    one position per cycle.
//  It drives the PE array position and the datapath's shift_en_4x4, and captures the
//    S16x16 result SAD_LAT cycles later.
//  It keeps a running minimum and returns the best MV and its SAD over a valid/ready handshake.

---
 rtl/sad_search_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/sad_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sad_search_ctrl
//  Purpose  : Full-search motion-estimation scheduler. It walks every integer
//             MV in the window and keeps the minimum-SAD candidate.
//  Revision : 1.0 - initial release
// ============================================================================
module sad_search_ctrl #(
  parameter int SAD_WIDTH = 16,
  parameter int RANGE     = 8,
  parameter int MV_WIDTH  = 5,
  parameter int SAD_LAT   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  output logic                        busy,
  output logic                        pe_load,
  output logic signed [MV_WIDTH-1:0]  pe_dx,
  output logic signed [MV_WIDTH-1:0]  pe_dy,
  output logic                        shift_en_4x4,
  input  logic        [SAD_WIDTH-1:0] sad_in,
  output logic                        done_valid,
  input  logic                        done_ready,
  output logic signed [MV_WIDTH-1:0]  best_dx,
  output logic signed [MV_WIDTH-1:0]  best_dy,
  output logic        [SAD_WIDTH-1:0] best_sad
);

  localparam int c_n_pos = (2 * RANGE) * (2 * RANGE);
  localparam int c_cnt_w = $clog2(c_n_pos) + 1;
  localparam int c_lat_w = (SAD_LAT > 1) ? $clog2(SAD_LAT) : 1;

  localparam logic signed [MV_WIDTH-1:0] c_mv_min     = MV_WIDTH'(-RANGE);
  localparam logic signed [MV_WIDTH-1:0] c_mv_max     = MV_WIDTH'(RANGE - 1);
  localparam logic signed [MV_WIDTH-1:0] c_mv_one     = MV_WIDTH'(1);
  localparam logic        [c_cnt_w-1:0]  c_last_pos   = c_cnt_w'(c_n_pos - 1);
  localparam logic        [c_lat_w-1:0]  c_drain_last = c_lat_w'(SAD_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                        r_busy;
  logic                        r_pe_load;
  logic                        r_done_valid;
  logic signed [MV_WIDTH-1:0]  r_pe_dx;
  logic signed [MV_WIDTH-1:0]  r_pe_dy;
  logic signed [MV_WIDTH-1:0]  r_best_dx;
  logic signed [MV_WIDTH-1:0]  r_best_dy;
  logic        [SAD_WIDTH-1:0] r_best_sad;
  logic        [c_cnt_w-1:0]   r_pos_cnt;
  logic        [c_lat_w-1:0]   r_drain_cnt;

  // Tag pipe: travels alongside the datapath so each sad_in knows its MV.
  logic                        r_tag_vld [SAD_LAT];
  logic signed [MV_WIDTH-1:0]  r_tag_dx  [SAD_LAT];
  logic signed [MV_WIDTH-1:0]  r_tag_dy  [SAD_LAT];

  logic w_abort;
  logic w_start;
  logic w_scan_last;
  logic w_drain_last;
  logic w_better;

  assign w_abort      = abort && (r_state != ST_IDLE);
  assign w_start      = start && (r_state == ST_IDLE);
  assign w_scan_last  = (r_pos_cnt == c_last_pos);
  assign w_drain_last = (r_drain_cnt == c_drain_last);
  assign w_better     = r_tag_vld[SAD_LAT-1] && (sad_in < r_best_sad);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start)                    w_state_nxt = ST_SCAN;
      ST_SCAN:  if (abort)                    w_state_nxt = ST_IDLE;
                else if (w_scan_last)         w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (abort)                    w_state_nxt = ST_IDLE;
                else if (w_drain_last)        w_state_nxt = ST_DONE;
      ST_DONE:  if (abort || done_ready)      w_state_nxt = ST_IDLE;
      default:                                w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy       <= 1'b0;
      r_pe_load    <= 1'b0;
      r_done_valid <= 1'b0;
    end else begin
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_pe_load    <= (w_state_nxt == ST_SCAN);
      r_done_valid <= (w_state_nxt == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pe_dx     <= '0;
      r_pe_dy     <= '0;
      r_pos_cnt   <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_start) begin
        r_pe_dx   <= c_mv_min;
        r_pe_dy   <= c_mv_min;
        r_pos_cnt <= '0;
      end else if (r_state == ST_SCAN && w_state_nxt == ST_SCAN) begin
        r_pos_cnt <= r_pos_cnt + c_cnt_w'(1);
        if (r_pe_dx == c_mv_max) begin
          r_pe_dx <= c_mv_min;
          r_pe_dy <= r_pe_dy + c_mv_one;
        end else begin
          r_pe_dx <= r_pe_dx + c_mv_one;
        end
      end

      if (r_state == ST_DRAIN) begin
        r_drain_cnt <= r_drain_cnt + c_lat_w'(1);
      end else begin
        r_drain_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SAD_LAT; i++) begin
        r_tag_vld[i] <= 1'b0;
        r_tag_dx[i]  <= '0;
        r_tag_dy[i]  <= '0;
      end
    end else if (w_abort) begin
      for (int i = 0; i < SAD_LAT; i++) begin
        r_tag_vld[i] <= 1'b0;
        r_tag_dx[i]  <= '0;
        r_tag_dy[i]  <= '0;
      end
    end else begin
      r_tag_vld[0] <= r_pe_load;
      r_tag_dx[0]  <= r_pe_dx;
      r_tag_dy[0]  <= r_pe_dy;
      for (int i = 1; i < SAD_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_dx[i]  <= r_tag_dx[i-1];
        r_tag_dy[i]  <= r_tag_dy[i-1];
      end
    end
  end

  // Strict less-than keeps the earliest raster position on ties.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_best_dx  <= '0;
      r_best_dy  <= '0;
      r_best_sad <= '1;
    end else if (w_start) begin
      r_best_dx  <= c_mv_min;
      r_best_dy  <= c_mv_min;
      r_best_sad <= '1;
    end else if (w_better && !w_abort) begin
      r_best_dx  <= r_tag_dx[SAD_LAT-1];
      r_best_dy  <= r_tag_dy[SAD_LAT-1];
      r_best_sad <= sad_in;
    end
  end

  assign busy         = r_busy;
  assign pe_load      = r_pe_load;
  assign shift_en_4x4 = r_pe_load;
  assign pe_dx        = r_pe_dx;
  assign pe_dy        = r_pe_dy;
  assign done_valid   = r_done_valid;
  assign best_dx      = r_best_dx;
  assign best_dy      = r_best_dy;
  assign best_sad     = r_best_sad;

endmodule
`default_nettype wire
